seg_cmd_controller: RTL and testbench

Command sequencer between the serial byte front-end (SPI/I2C slave) and the 7-segment output pins. It accepts a byte stream over a valid/ready handshake and parses two-byte commands (opcode, operand). It updates the display registers and applies a prescaled blink, driving seg_out/dp_out directly onto uo_out. It also flags malformed or stalled commands.

---
 rtl/seg_pkg.sv | 48 ++++
 rtl/blink_prescaler.sv | 33 +++
 rtl/seg_cmd_controller.sv | 189 ++++++++++++++++++
 tb/tb_seg_cmd_controller.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display blocks.
// Holds the command opcodes, the command FSM state encoding and the
// hex-to-segment decode table reused by other display blocks.
package seg_pkg;

  // Command opcodes (first byte of a two-byte command)
  localparam logic [7:0] OP_SET_HEX   = 8'h01;
  localparam logic [7:0] OP_SET_RAW   = 8'h02;
  localparam logic [7:0] OP_SET_BLINK = 8'h03;
  localparam logic [7:0] OP_SET_DP    = 8'h04;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_OP = 2'd1,
    APPLY   = 2'd2
  } state_t;

  // Anything outside 0x01..0x04 is rejected at the opcode byte.
  function automatic logic is_legal_opcode(input logic [7:0] op);
    return (op == OP_SET_HEX)   || (op == OP_SET_RAW) ||
           (op == OP_SET_BLINK) || (op == OP_SET_DP);
  endfunction

  // Segment pattern in gfedcba order, active-high.
  function automatic logic [6:0] hexdecode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/blink_prescaler.sv
// Blink phase generator: free-running counter 0..MAX_COUNT-1, phase toggles on wrap.
// Latency: phase changes the cycle after the wrap edge; clear takes effect at the next edge.
// Backpressure: none, runs every cycle regardless of whether blinking is enabled.
//
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset (counter 0, phase 1)
//   clear - synchronous restart of the blink period (counter 0, phase 1)
//   phase - current blink phase; 1 = lit half, 0 = dark half
module blink_prescaler #(
  parameter logic [23:0] MAX_COUNT = 24'd10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic phase
);

  logic [23:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt == MAX_COUNT - 24'd1) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 24'd1;
    end
  end

endmodule

// File: rtl/seg_cmd_controller.sv
// Two-byte command sequencer (opcode, operand) driving the 7-segment pins with optional blink.
// Latency: operand accepted at edge N -> APPLY; display registers and pins update at edge N+1.
// Backpressure: cmd_ready drops only during the single APPLY cycle; otherwise every byte is taken.
//
// Ports:
//   clk       - system clock
//   rst       - synchronous active-high reset, overrides everything
//   cmd_valid - byte on cmd_data is valid
//   cmd_data  - opcode or operand byte
//   cmd_ready - controller accepts a byte this cycle
//   seg_out   - registered segment drive (gfedcba), blanked during the dark blink phase
//   dp_out    - registered decimal point, gated like seg_out
//   busy      - a command is in progress (state is not IDLE)
//   err       - one-cycle pulse on illegal opcode or operand timeout
module seg_cmd_controller
  import seg_pkg::*;
#(
  parameter logic [23:0] MAX_COUNT = 24'd10_000_000,
  parameter logic [15:0] TIMEOUT   = 16'd1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic       busy,
  output logic       err
);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [7:0]  opcode_q;
  logic [6:0]  operand_q;      // bit 7 of the operand is never used by any opcode
  logic [15:0] wait_cnt_q;

  logic [6:0]  seg_reg_q, seg_reg_d;
  logic        dp_reg_q, dp_reg_d;
  logic        blink_en_q, blink_en_d;
  logic        blink_clear;

  logic        phase;
  logic        phase_eff;
  logic        xfer;
  logic        err_d;
  logic        latch_opcode;
  logic        latch_operand;
  logic        wait_clr;
  logic        wait_inc;

  assign cmd_ready = (state_q != APPLY);
  assign busy      = (state_q != IDLE);
  assign xfer      = cmd_valid && cmd_ready;

  // ---------------------------------------------------------------------
  // Command FSM: next state and control strobes
  // ---------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    err_d         = 1'b0;
    latch_opcode  = 1'b0;
    latch_operand = 1'b0;
    wait_clr      = 1'b0;
    wait_inc      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          latch_opcode = 1'b1;
          if (is_legal_opcode(cmd_data)) begin
            state_d  = WAIT_OP;
            wait_clr = 1'b1;
          end else begin
            // Illegal opcode: no operand follows, stay ready for the next opcode.
            err_d = 1'b1;
          end
        end
      end

      WAIT_OP: begin
        // A byte arriving in the expiry cycle still counts as the operand.
        if (xfer) begin
          latch_operand = 1'b1;
          state_d       = APPLY;
        end else if (wait_cnt_q == TIMEOUT - 16'd1) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wait_inc = 1'b1;
        end
      end

      APPLY: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Display register update, only in APPLY
  // ---------------------------------------------------------------------
  always_comb begin
    seg_reg_d   = seg_reg_q;
    dp_reg_d    = dp_reg_q;
    blink_en_d  = blink_en_q;
    blink_clear = 1'b0;

    if (state_q == APPLY) begin
      case (opcode_q)
        OP_SET_HEX:   seg_reg_d = hexdecode(operand_q[3:0]);
        OP_SET_RAW:   seg_reg_d = operand_q;
        OP_SET_BLINK: begin
          blink_en_d  = operand_q[0];
          blink_clear = 1'b1;
        end
        OP_SET_DP:    dp_reg_d = operand_q[0];
        default:      ;
      endcase
    end
  end

  // The prescaler's own phase lags a clear by one edge; a restarted period
  // always begins lit, so force that here to avoid a one-cycle dark glitch.
  assign phase_eff = blink_clear ? 1'b1 : phase;

  // ---------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      opcode_q   <= '0;
      operand_q  <= '0;
      wait_cnt_q <= '0;
      seg_reg_q  <= '0;
      dp_reg_q   <= 1'b0;
      blink_en_q <= 1'b0;
      seg_out    <= '0;
      dp_out     <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      seg_reg_q  <= seg_reg_d;
      dp_reg_q   <= dp_reg_d;
      blink_en_q <= blink_en_d;
      err        <= err_d;

      if (latch_opcode) begin
        opcode_q <= cmd_data;
      end
      if (latch_operand) begin
        operand_q <= cmd_data[6:0];
      end

      if (wait_clr) begin
        wait_cnt_q <= '0;
      end else if (wait_inc) begin
        wait_cnt_q <= wait_cnt_q + 16'd1;
      end

      // New register contents reach the pins at the same edge they are
      // written; the blink phase is sampled from the previous cycle.
      if (blink_en_d && !phase_eff) begin
        seg_out <= '0;
        dp_out  <= 1'b0;
      end else begin
        seg_out <= seg_reg_d;
        dp_out  <= dp_reg_d;
      end
    end
  end

  blink_prescaler #(
    .MAX_COUNT (MAX_COUNT)
  ) u_blink_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (blink_clear),
    .phase (phase)
  );

endmodule

// File: tb/tb_seg_cmd_controller.sv
// Directed bench for seg_cmd_controller with MAX_COUNT=4 and TIMEOUT=8.
module tb_seg_cmd_controller;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic [6:0] seg_out;
  logic       dp_out;
  logic       busy;
  logic       err;

  int n_vec  = 0;
  int n_fail = 0;

  seg_cmd_controller #(
    .MAX_COUNT (24'd4),
    .TIMEOUT   (16'd8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .seg_out   (seg_out),
    .dp_out    (dp_out),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row: outputs expected at this negedge, then inputs for the next posedge.
  typedef struct {
    logic       rdy;
    logic       bsy;
    logic       er;
    logic [6:0] seg;
    logic       dp;
    logic       v;
    logic [7:0] d;
  } vec_t;

  function automatic vec_t mk(input logic rdy, input logic bsy, input logic er,
                              input logic [6:0] seg, input logic dp,
                              input logic v, input logic [7:0] d);
    vec_t r;
    r.rdy = rdy; r.bsy = bsy; r.er = er; r.seg = seg; r.dp = dp; r.v = v; r.d = d;
    return r;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic rdy, input logic bsy, input logic er,
                         input logic [6:0] seg, input logic dp);
    chk({tag, ".cmd_ready"}, {7'd0, cmd_ready}, {7'd0, rdy});
    chk({tag, ".busy"},      {7'd0, busy},      {7'd0, bsy});
    chk({tag, ".err"},       {7'd0, err},       {7'd0, er});
    chk({tag, ".seg_out"},   {1'b0, seg_out},   {1'b0, seg});
    chk({tag, ".dp_out"},    {7'd0, dp_out},    {7'd0, dp});
  endtask

  // Advance one full cycle, returning at the following negedge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    cmd_valid = v;
    cmd_data  = d;
  endtask

  vec_t tbl [19];

  initial begin
    logic [6:0] exp_seg;

    tbl[0]  = mk(1, 0, 0, 7'h00, 0, 1, 8'h01); // SET_HEX opcode
    tbl[1]  = mk(1, 1, 0, 7'h00, 0, 1, 8'h05); // operand back-to-back
    tbl[2]  = mk(0, 1, 0, 7'h00, 0, 0, 8'h00); // APPLY
    tbl[3]  = mk(1, 0, 0, 7'h6D, 0, 1, 8'h02); // '5' shown; SET_RAW
    tbl[4]  = mk(1, 1, 0, 7'h6D, 0, 1, 8'hFF);
    tbl[5]  = mk(0, 1, 0, 7'h6D, 0, 0, 8'h00);
    tbl[6]  = mk(1, 0, 0, 7'h7F, 0, 1, 8'h04); // bit7 dropped; SET_DP
    tbl[7]  = mk(1, 1, 0, 7'h7F, 0, 1, 8'h01);
    tbl[8]  = mk(0, 1, 0, 7'h7F, 0, 0, 8'h00);
    tbl[9]  = mk(1, 0, 0, 7'h7F, 1, 1, 8'h07); // dp on; illegal 0x07
    tbl[10] = mk(1, 0, 1, 7'h7F, 1, 1, 8'h01); // err pulse, still IDLE
    tbl[11] = mk(1, 1, 0, 7'h7F, 1, 1, 8'h0A);
    tbl[12] = mk(0, 1, 0, 7'h7F, 1, 1, 8'h07); // byte offered in APPLY is dropped
    tbl[13] = mk(1, 0, 0, 7'h77, 1, 1, 8'h00); // 'A'; illegal 0x00
    tbl[14] = mk(1, 0, 1, 7'h77, 1, 1, 8'hFF); // illegal 0xFF back-to-back
    tbl[15] = mk(1, 0, 1, 7'h77, 1, 1, 8'h01);
    tbl[16] = mk(1, 1, 0, 7'h77, 1, 1, 8'hF3); // upper nibble ignored
    tbl[17] = mk(0, 1, 0, 7'h77, 1, 0, 8'h00);
    tbl[18] = mk(1, 0, 0, 7'h4F, 1, 0, 8'h00);

    rst = 1'b1;
    drive(0, 8'h00);
    repeat (3) tick();
    chk_all("reset", 1, 0, 0, 7'h00, 0);
    rst = 1'b0;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 19; i++) begin
      chk_all($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].bsy, tbl[i].er, tbl[i].seg, tbl[i].dp);
      drive(tbl[i].v, tbl[i].d);
      tick();
    end

    // ---------------- operand timeout ----------------
    drive(1, 8'h01);
    tick();
    drive(0, 8'h00);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("to_wait%0d.busy", k), {7'd0, busy}, 8'd1);
      chk($sformatf("to_wait%0d.err", k),  {7'd0, err},  8'd0);
      tick();
    end
    chk("to_expire.busy", {7'd0, busy}, 8'd0);
    chk("to_expire.err",  {7'd0, err},  8'd1);
    tick();
    chk("to_after.err",  {7'd0, err},  8'd0);
    chk("to_after.busy", {7'd0, busy}, 8'd0);
    drive(1, 8'h03);                      // late byte parsed as an opcode
    tick();
    chk("to_late.busy",  {7'd0, busy},      8'd1);
    chk("to_late.ready", {7'd0, cmd_ready}, 8'd1);
    chk("to_late.err",   {7'd0, err},       8'd0);
    drive(1, 8'h00);                      // blink off, restarts period
    tick();
    drive(0, 8'h00);
    tick();
    chk_all("to_done", 1, 0, 0, 7'h4F, 1);

    // ---------------- operand arriving in the expiry cycle ----------------
    drive(1, 8'h01);
    tick();
    drive(0, 8'h00);
    repeat (7) tick();
    chk("tie_pre.busy", {7'd0, busy}, 8'd1);
    chk("tie_pre.err",  {7'd0, err},  8'd0);
    drive(1, 8'h0C);
    tick();
    chk_all("tie_apply", 0, 1, 0, 7'h4F, 1);
    drive(0, 8'h00);
    tick();
    chk_all("tie_done", 1, 0, 0, 7'h39, 1);

    // ---------------- blink ----------------
    drive(1, 8'h01); tick();
    drive(1, 8'h08); tick();
    drive(0, 8'h00); tick();
    chk("blk_pre.seg", {1'b0, seg_out}, 8'h7F);
    drive(1, 8'h03); tick();
    drive(1, 8'h01); tick();
    drive(0, 8'h00); tick();              // APPLY edge of SET_BLINK 1
    for (int k = 0; k < 17; k++) begin
      exp_seg = (k == 0 || (((k - 1) / 4) % 2) == 0) ? 7'h7F : 7'h00;
      chk($sformatf("blk%0d.seg", k), {1'b0, seg_out}, {1'b0, exp_seg});
      chk($sformatf("blk%0d.dp", k),  {7'd0, dp_out},  {7'd0, (exp_seg != 7'h00)});
      tick();
    end
    drive(1, 8'h03); tick();
    drive(1, 8'h00); tick();
    drive(0, 8'h00); tick();
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("steady%0d.seg", k), {1'b0, seg_out}, 8'h7F);
      chk($sformatf("steady%0d.dp", k),  {7'd0, dp_out},  8'd1);
      tick();
    end

    // ---------------- reset mid-command ----------------
    drive(1, 8'h01);
    tick();
    chk("rst_pre.busy", {7'd0, busy}, 8'd1);
    rst = 1'b1;
    drive(1, 8'h02);                      // offered byte must lose to reset
    tick();
    chk_all("rst_mid", 1, 0, 0, 7'h00, 0);
    rst = 1'b0;
    drive(0, 8'h00);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_all($sformatf("rst_hold%0d", k), 1, 0, 0, 7'h00, 0);
    end
    drive(1, 8'h05);                      // taken as an opcode, and 0x05 is illegal
    tick();
    chk_all("rst_op05", 1, 0, 1, 7'h00, 0);
    drive(0, 8'h00);
    tick();
    chk_all("rst_op05_after", 1, 0, 0, 7'h00, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
